// File: rtl/cmp_seq_ctrl.sv
// Multi-cycle magnitude comparator: walks WIDTH-bit operands one SLICE-bit slice
// per cycle, MSB slice first, and exits at the first unequal slice.
module cmp_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [WIDTH-1:0]                  A,
    input  logic [WIDTH-1:0]                  B,
    input  logic                              l,
    input  logic                              e,
    input  logic                              g,
    output logic                              busy,
    output logic                              done,
    output logic                              lt,
    output logic                              eq,
    output logic                              gt,
    output logic [$clog2(WIDTH/SLICE):0]      nslc
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             l_q;
    logic             e_q;
    logic             g_q;
    logic [IW-1:0]    idx;
    logic [CW-1:0]    cnt;

    // Slice views of the latched operands; idx picks one for the shared comparator.
    logic [SLICE-1:0] a_sl [N];
    logic [SLICE-1:0] b_sl [N];

    for (genvar i = 0; i < N; i++) begin : g_slice
        assign a_sl[i] = a_q[i*SLICE +: SLICE];
        assign b_sl[i] = b_q[i*SLICE +: SLICE];
    end

    logic [SLICE-1:0] sa;
    logic [SLICE-1:0] sb;
    logic             slice_gt;
    logic             slice_lt;

    always_comb begin
        sa       = a_sl[idx];
        sb       = b_sl[idx];
        slice_gt = (sa > sb);
        slice_lt = (sa < sb);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            gt    <= 1'b0;
            nslc  <= '0;
            idx   <= IW'(N - 1);
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            l_q   <= 1'b0;
            e_q   <= 1'b0;
            g_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        l_q   <= l;
                        e_q   <= e;
                        g_q   <= g;
                        idx   <= IW'(N - 1);
                        cnt   <= CW'(1);
                        busy  <= 1'b1;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (slice_gt || slice_lt || (idx == '0)) begin
                        // Equal all the way down: pass the cascade input through untouched.
                        if (slice_gt) begin
                            {lt, eq, gt} <= 3'b001;
                        end else if (slice_lt) begin
                            {lt, eq, gt} <= 3'b100;
                        end else begin
                            {lt, eq, gt} <= {l_q, e_q, g_q};
                        end
                        nslc  <= cnt;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_seq_ctrl.sv
// Scoreboard bench for cmp_seq_ctrl: a driver pushes model results, a negedge
// monitor checks every cycle's busy/done/result against them.
module tb_cmp_seq_ctrl;

    localparam int WIDTH = 32;
    localparam int SLICE = 4;
    localparam int N     = WIDTH / SLICE;
    localparam int NW    = $clog2(N) + 1;
    localparam int EW    = 32 + NW + 3;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             l;
    logic             e;
    logic             g;
    logic             busy;
    logic             done;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [NW-1:0]    nslc;

    cmp_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .l     (l),
        .e     (e),
        .g     (g),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt),
        .nslc  (nslc)
    );

    // ---------------- clock / edge counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard state ----------------
    // Entry: {done edge, nslc, lt, eq, gt}
    logic [EW-1:0]     exp_q[$];
    logic [NW+2:0]     last_res = '0;
    int unsigned       bs = 0;
    int unsigned       be = 0;
    int                vecs = 0;
    int                errs = 0;
    bit                checking = 0;

    // Reference: a full-width compare decides the answer; the highest differing
    // bit tells which slice ended the walk.
    function automatic logic [NW+2:0] model(input logic [WIDTH-1:0] ma,
                                            input logic [WIDTH-1:0] mb,
                                            input logic [2:0] leg);
        logic [WIDTH-1:0] x;
        int               p;
        int               k;
        logic [2:0]       r;
        x = ma ^ mb;
        if (x == 0) begin
            k = N;
            r = leg;
        end else begin
            p = 0;
            for (int i = 0; i < WIDTH; i++) if (x[i]) p = i;
            k = N - p / SLICE;
            r = (ma < mb) ? 3'b100 : 3'b001;
        end
        return {NW'(k), r};
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (checking) begin
            logic [EW-1:0]   ex;
            logic [NW+2:0]   act;
            logic            exp_busy;
            act = {nslc, lt, eq, gt};
            if (done) begin
                vecs++;
                if (exp_q.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_done edge=%0d got {nslc,lt,eq,gt}=%h, none expected", edge_cnt, act);
                end else begin
                    ex = exp_q.pop_front();
                    if (act !== ex[NW+2:0] || ex[EW-1 -: 32] != edge_cnt) begin
                        errs++;
                        $display("FAIL result edge=%0d got {nslc,lt,eq,gt}=%h expected %h at edge %0d",
                                 edge_cnt, act, ex[NW+2:0], ex[EW-1 -: 32]);
                    end
                    last_res = ex[NW+2:0];
                end
            end else begin
                vecs++;
                if (act !== last_res) begin
                    errs++;
                    $display("FAIL hold edge=%0d got {nslc,lt,eq,gt}=%h expected %h", edge_cnt, act, last_res);
                end
                if (exp_q.size() > 0 && ex_edge(exp_q[0]) <= edge_cnt) begin
                    ex = exp_q.pop_front();
                    errs++;
                    $display("FAIL missing_done edge=%0d got done=0 expected done=1", edge_cnt);
                    last_res = ex[NW+2:0];
                end
            end
            exp_busy = (edge_cnt >= bs) && (edge_cnt < be);
            vecs++;
            if (busy !== exp_busy) begin
                errs++;
                $display("FAIL busy edge=%0d got %b expected %b", edge_cnt, busy, exp_busy);
            end
        end
    end

    function automatic int unsigned ex_edge(input logic [EW-1:0] x);
        return x[EW-1 -: 32];
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge when the DUT will accept start at the next edge.
    task automatic issue(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic [2:0] leg, input bit hold);
        logic [NW+2:0] r;
        int unsigned   acc;
        r   = model(ta, tb, leg);
        acc = edge_cnt + 1;
        a = ta; b = tb; {l, e, g} = leg; start = 1'b1;
        exp_q.push_back({acc + 32'(r[NW+2:3]), r});
        bs = acc;
        be = acc + 32'(r[NW+2:3]);
        @(negedge clk);
        if (!hold) start = 1'b0;
        a = $urandom; b = $urandom; {l, e, g} = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            vecs++;
            errs++;
            $display("FAIL timeout edge=%0d got done=%b expected done=1", edge_cnt, done);
        end
    endtask

    task automatic run(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input logic [2:0] leg);
        issue(ta, tb, leg, 1'b0);
        wait_done();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; {l, e, g} = 3'b000;
        @(posedge clk); #1;
        checking = 1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run(32'h41414141, 32'h41414141, 3'b010);
        run(32'h80000000, 32'h7FFFFFFF, 3'b010);
        run(32'h7FFFFFFF, 32'h80000000, 3'b010);
        run(32'h12345670, 32'h12345678, 3'b010);
        run(32'h40000000, 32'h0D000000, 3'b010);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b100);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b001);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 3'b000);

        // Starts during a busy compare are ignored
        issue(32'h00000005, 32'h00000003, 3'b010, 1'b0);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; a = $urandom; b = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done();

        // Back-to-back: start during the done cycle
        issue(32'hA5A5A5A5, 32'hA5A5A5A5, 3'b110, 1'b0);
        wait_done();
        issue(32'h0000_0010, 32'h0000_0011, 3'b010, 1'b0);
        wait_done();
        @(negedge clk);

        // start held high across several compares
        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i % 2 == 0) ? ra : (ra ^ (32'h1 << (4 * i)));
            issue(ra, rb, 3'($urandom_range(0, 7)), i != 3);
            wait_done();
        end
        @(negedge clk);

        // Reset in the middle of a compare
        issue(32'h41414141, 32'h41414140, 3'b010, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        bs = 0; be = 0; last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(32'h41414141, 32'h41414140, 3'b010);

        // Random compares, biased toward equal and single-slice differences
        for (int i = 0; i < 80; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ (32'($urandom_range(1, 15)) << (4 * $urandom_range(0, N - 1)));
                default: rb = $urandom;
            endcase
            issue(ra, rb, 3'($urandom_range(0, 7)), 1'b0);
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain got %0d pending results expected 0", exp_q.size());
        end
        checking = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
